// File: rtl/axis_gen_pkg.sv
// axis_gen_pkg
// Shared types and helpers for the AXI-Stream packet generator:
//   TDATA_W_DEF  default stream width (multiple of 32)
//   LEN_W        width of beat index, length and packet sequence fields
//   gen_state_e  generator FSM states
//   pattern_word one 32-bit pattern word {seq, beat}
//   pattern      full-width default pattern (the word replicated)
//   clamp_len    maps a requested length into 1..max_len
package axis_gen_pkg;

  localparam int TDATA_W_DEF = 256;
  localparam int LEN_W       = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } gen_state_e;

  function automatic logic [31:0] pattern_word(input logic [LEN_W-1:0] seq,
                                               input logic [LEN_W-1:0] beat);
    pattern_word = {seq, beat};
  endfunction

  function automatic logic [TDATA_W_DEF-1:0] pattern(input logic [LEN_W-1:0] seq,
                                                     input logic [LEN_W-1:0] beat);
    pattern = {(TDATA_W_DEF / 32){pattern_word(seq, beat)}};
  endfunction

  // A zero-length request still produces one beat; oversize requests saturate.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] max_len);
    if (len == {LEN_W{1'b0}}) begin
      clamp_len = {{(LEN_W-1){1'b0}}, 1'b1};
    end else if (len > max_len) begin
      clamp_len = max_len;
    end else begin
      clamp_len = len;
    end
  endfunction

endpackage

// File: rtl/axis_packet_generator_start_sync_edge.sv
// start_sync_edge
// Brings an asynchronous button level into the clk domain and produces a
// single-cycle pulse on its rising edge.
//   clk    system clock
//   resent synchronous active-high reset, clears all three flops
//   din    asynchronous level input
//   pulse  one-cycle high pulse, rising edge of the synchronised level
module start_sync_edge (
  input  logic clk,
  input  logic resent,
  input  logic din,
  output logic pulse
);

  logic sync1_r;
  logic sync2_r;
  logic hist_r;

  // Two-stage synchroniser followed by a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (resent) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      hist_r  <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      hist_r  <= sync2_r;
    end
  end

  // Gate of two flops only, so the consumer sees the request on the third
  // edge after the button is first sampled high.
  assign pulse = sync2_r & ~hist_r;

endmodule

// File: rtl/axis_packet_generator.sv
// axis_packet_generator
// AXI-Stream source emitting patterned packets on a button request, with an
// optional continuous mode separated by GAP_CYCLES idle cycles.
//   clk, resent           clock and synchronous active-high reset
//   start                 asynchronous button level; rising edge requests a packet
//   continuous            repeat packets; sampled at each packet boundary
//   pkt_len               requested beats per packet (clamped to 1..MAX_BEATS)
//   tdata/tvalid/tlast    AXI-Stream master outputs, all registered
//   tready                downstream ready
//   busy                  high while in SEND or GAP
//   pkt_count             completed packets, wraps at 2^32
module axis_packet_generator
  import axis_gen_pkg::*;
#(
  parameter int TDATA_W    = TDATA_W_DEF,
  parameter int MAX_BEATS  = 4096,
  parameter int GAP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               resent,
  input  logic               start,
  input  logic               continuous,
  input  logic [15:0]        pkt_len,
  output logic [TDATA_W-1:0] tdata,
  output logic               tvalid,
  output logic               tlast,
  input  logic               tready,
  output logic               busy,
  output logic [31:0]        pkt_count
);

  localparam int              WORDS    = TDATA_W / 32;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BEATS);
  localparam logic [LEN_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? LEN_W'(GAP_CYCLES - 1) : {LEN_W{1'b0}};
  localparam bit              HAS_GAP  = (GAP_CYCLES > 0);

  gen_state_e       state_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] beat_r;
  logic [LEN_W-1:0] seq_r;
  logic [LEN_W-1:0] gap_cnt_r;

  logic             start_pulse_s;
  logic [LEN_W-1:0] len_clamped_s;
  logic [LEN_W-1:0] beat_next_s;
  logic [LEN_W-1:0] seq_next_s;
  logic             last_beat_s;
  logic             next_is_last_s;

  start_sync_edge u_start_sync (
    .clk    (clk),
    .resent (resent),
    .din    (start),
    .pulse  (start_pulse_s)
  );

  assign len_clamped_s  = clamp_len(pkt_len, MAX_LEN);
  assign beat_next_s    = beat_r + 16'd1;
  assign seq_next_s     = seq_r + 16'd1;
  assign last_beat_s    = (beat_r == (len_r - 16'd1));
  assign next_is_last_s = (beat_next_s == (len_r - 16'd1));

  // Generator FSM; every stream output is a register so tvalid never
  // depends on tready within a cycle and data holds until handshake.
  always_ff @(posedge clk) begin
    if (resent) begin
      state_r   <= IDLE;
      len_r     <= 16'd0;
      beat_r    <= 16'd0;
      seq_r     <= 16'd0;
      gap_cnt_r <= 16'd0;
      tdata     <= {TDATA_W{1'b0}};
      tvalid    <= 1'b0;
      tlast     <= 1'b0;
      busy      <= 1'b0;
      pkt_count <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_pulse_s) begin
            state_r <= SEND;
            busy    <= 1'b1;
            len_r   <= len_clamped_s;
            beat_r  <= 16'd0;
            tdata   <= {WORDS{pattern_word(seq_r, 16'd0)}};
            tvalid  <= 1'b1;
            tlast   <= (len_clamped_s == 16'd1);
          end
        end
        SEND: begin
          if (tvalid && tready) begin
            if (last_beat_s) begin
              pkt_count <= pkt_count + 32'd1;
              seq_r     <= seq_next_s;
              if (continuous && HAS_GAP) begin
                state_r   <= GAP;
                gap_cnt_r <= 16'd0;
                tvalid    <= 1'b0;
                tlast     <= 1'b0;
              end else if (continuous) begin
                // Back-to-back: tvalid stays high, next packet starts now.
                len_r  <= len_clamped_s;
                beat_r <= 16'd0;
                tdata  <= {WORDS{pattern_word(seq_next_s, 16'd0)}};
                tlast  <= (len_clamped_s == 16'd1);
              end else begin
                state_r <= IDLE;
                busy    <= 1'b0;
                tvalid  <= 1'b0;
                tlast   <= 1'b0;
              end
            end else begin
              beat_r <= beat_next_s;
              tdata  <= {WORDS{pattern_word(seq_r, beat_next_s)}};
              tlast  <= next_is_last_s;
            end
          end
        end
        GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            if (continuous) begin
              state_r <= SEND;
              len_r   <= len_clamped_s;
              beat_r  <= 16'd0;
              tdata   <= {WORDS{pattern_word(seq_r, 16'd0)}};
              tvalid  <= 1'b1;
              tlast   <= (len_clamped_s == 16'd1);
            end else begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            gap_cnt_r <= gap_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          tvalid  <= 1'b0;
          tlast   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_generator.sv
// tb_axis_packet_generator
// Scoreboard bench: stimulus pushes expected beats computed from the packet
// rules; an independent monitor pops and compares on every handshake, and
// also checks hold-while-stalled, tlast/busy consistency and gap length.
module tb_axis_packet_generator;

  localparam int W   = 256;
  localparam int MAXB = 4096;
  localparam int GAP = 4;

  logic          clk;
  logic          resent;
  logic          start;
  logic          continuous;
  logic [15:0]   pkt_len;
  logic [W-1:0]  tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;
  logic          busy;
  logic [31:0]   pkt_count;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  beat_t       exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          hs_count = 0;
  int          tmode    = 0;
  logic [15:0] seq_m    = 16'd0;
  int          pkts_m   = 0;

  axis_packet_generator #(.TDATA_W(W), .MAX_BEATS(MAXB), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .resent     (resent),
    .start      (start),
    .continuous (continuous),
    .pkt_len    (pkt_len),
    .tdata      (tdata),
    .tvalid     (tvalid),
    .tlast      (tlast),
    .tready     (tready),
    .busy       (busy),
    .pkt_count  (pkt_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: a packet is clamp(len) beats, word {seq, beat} replicated, tlast on the final one.
  task automatic push_packet(input int len);
    int    n;
    beat_t b;
    n = (len == 0) ? 1 : ((len > MAXB) ? MAXB : len);
    for (int i = 0; i < n; i++) begin
      b.data = {(W/32){seq_m, 16'(i)}};
      b.last = (i == n - 1);
      exp_q.push_back(b);
    end
    seq_m  = seq_m + 16'd1;
    pkts_m = pkts_m + 1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    repeat (5) @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n = 0;
    while (hs_count < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_handshakes", W'(hs_count >= target), W'(1));
  endtask

  task automatic drain_and_check(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drain"}, W'(exp_q.size()), W'(0));
    exp_q.delete();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check({name, "_pkt_count"}, W'(pkt_count), W'(pkts_m));
    check({name, "_busy"}, W'(busy), W'(0));
    check({name, "_tvalid"}, W'(tvalid), W'(0));
    @(posedge clk); #1;
  endtask

  // tready driver: always ready, random, or the fixed 1,0,0,1,0,1,1 pattern over valid cycles.
  initial begin
    logic [6:0] pat;
    int         pidx;
    pat    = 7'b1101001;
    pidx   = 0;
    tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (tmode)
        1: tready = ($urandom_range(0, 2) != 0);
        2: begin
          if (tvalid) begin
            tready = (pidx < 7) ? pat[pidx] : 1'b1;
            pidx++;
          end else begin
            tready = 1'b1;
          end
        end
        default: begin
          tready = 1'b1;
          pidx   = 0;
        end
      endcase
    end
  end

  // Monitor: samples mid-cycle, compares each handshake against the scoreboard.
  initial begin
    logic         stall_q;
    logic [W-1:0] stall_data;
    logic         stall_last;
    logic         gap_armed;
    int           gap_run;
    beat_t        e;
    stall_q   = 1'b0;
    gap_armed = 1'b0;
    gap_run   = 0;
    forever begin
      @(negedge clk);
      if (resent) begin
        stall_q   = 1'b0;
        gap_armed = 1'b0;
      end else begin
        if (stall_q) begin
          check("hold_tvalid", W'(tvalid), W'(1));
          check("hold_tdata", tdata, stall_data);
          check("hold_tlast", W'(tlast), W'(stall_last));
        end
        if (tvalid) check("busy_in_send", W'(busy), W'(1));
        else        check("tlast_without_tvalid", W'(tlast), W'(0));
        if (gap_armed) begin
          if (tvalid) begin
            check("gap_cycles", W'(gap_run), W'(GAP));
            gap_armed = 1'b0;
          end else begin
            gap_run++;
          end
        end
        if (tvalid && tready) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", W'(1), W'(0));
          end else begin
            e = exp_q.pop_front();
            check("beat_tdata", tdata, e.data);
            check("beat_tlast", W'(tlast), W'(e.last));
          end
          if (tlast) begin
            gap_armed = continuous;
            gap_run   = 0;
          end
        end
        stall_q    = tvalid && !tready;
        stall_data = tdata;
        stall_last = tlast;
      end
    end
  end

  initial begin
    int base;
    resent     = 1'b1;
    start      = 1'b0;
    continuous = 1'b0;
    pkt_len    = 16'd0;
    repeat (3) @(posedge clk);
    #1 resent = 1'b0;

    // Reset then idle.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_tvalid", W'(tvalid), W'(0));
      check("idle_busy", W'(busy), W'(0));
      check("idle_pkt_count", W'(pkt_count), W'(0));
      check("idle_tdata", tdata, W'(0));
    end
    @(posedge clk); #1;

    // Single packet, always ready.
    pkt_len = 16'd4;
    push_packet(4);
    pulse_start();
    drain_and_check(100, "single");

    // Back-pressure pattern.
    tmode   = 2;
    pkt_len = 16'd3;
    push_packet(3);
    pulse_start();
    drain_and_check(100, "backpressure");
    tmode = 0;

    // Continuous: three packets, clear during the third.
    continuous = 1'b1;
    pkt_len    = 16'd2;
    base       = hs_count;
    push_packet(2);
    push_packet(2);
    push_packet(2);
    pulse_start();
    wait_hs(base + 5, 200);
    continuous = 1'b0;
    drain_and_check(100, "continuous");

    // Zero length becomes one beat.
    pkt_len = 16'd0;
    push_packet(0);
    pulse_start();
    drain_and_check(100, "len_zero");

    // Oversize clamps, and a second start mid-packet is ignored.
    pkt_len = 16'd5000;
    base    = hs_count;
    push_packet(5000);
    pulse_start();
    wait_hs(base + 100, 500);
    pulse_start();
    drain_and_check(6000, "len_clamp");

    // Randomised packets under random back-pressure.
    tmode = 1;
    for (int k = 0; k < 8; k++) begin
      pkt_len = 16'($urandom_range(0, 12));
      push_packet(int'(pkt_len));
      pulse_start();
      drain_and_check(300, "random");
    end
    tmode = 0;

    // Reset mid-packet after the fourth handshake.
    pkt_len = 16'd8;
    base    = hs_count;
    push_packet(8);
    pulse_start();
    wait_hs(base + 4, 100);
    resent = 1'b1;
    exp_q.delete();
    seq_m  = 16'd0;
    pkts_m = 0;
    @(posedge clk); #1 resent = 1'b0;
    @(negedge clk);
    check("rst_mid_tvalid", W'(tvalid), W'(0));
    check("rst_mid_tlast", W'(tlast), W'(0));
    check("rst_mid_pkt_count", W'(pkt_count), W'(0));
    check("rst_mid_tdata", tdata, W'(0));
    @(posedge clk); #1;
    pkt_len = 16'd3;
    push_packet(3);
    pulse_start();
    drain_and_check(100, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
